mouse_cmd_sequencer: RTL and testbench
======================================

Name: mouse_cmd_sequencer

Overview:
Host-side command sequencer for the PS/2 mouse link. It queues command bytes written by the processor bus, such as F3+rate, E8+res or F5/F4, and owns the PS/2 transmitter handshake. For each byte it waits for the mouse ACK, retries on resend, times out, and reports completion or error. It sits between the bus register interface and the PS/2 transmitter/receiver pair, as an alternative master to the stream-mode state machine during configuration.

Parameters:
FIFO_DEPTH, 4, command-byte queue depth (power of 2, >=2)
ACK_TIMEOUT, 50000, cycles allowed per wait state, 1 ms at 50 MHz; must be >=2
MAX_RETRY, 2, resend attempts per byte after the first send

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous active-low reset
CMD_WR  in  1  bus write strobe, one byte per cycle
CMD_DATA  in  8  command byte to queue
CMD_FULL  out  1  queue count == FIFO_DEPTH
CMD_OVF  out  1  one-cycle pulse: write dropped because queue full
SEND_BYTE  out  1  one-cycle request to transmitter
BYTE_TO_SEND  out  8  byte for transmitter
BYTE_SENT  in  1  transmitter done pulse
READ_ENABLE  out  1  receiver enable
BYTE_READ  in  8  received byte
BYTE_ERROR_CODE  in  2  receiver error, 0 = ok
BYTE_READY  in  1  received-byte strobe
BUSY  out  1  high when not IDLE or queue not empty
DONE  out  1  one-cycle pulse: head byte ACKed
ERROR  out  1  one-cycle pulse: head byte failed
ERR_CODE  out  2  last error: 01 timeout, 10 NACK (FC), 11 resend limit

Behaviour:
- Reset (RESET low at CLK edge):
  - queue emptied; state IDLE; retry and timer counters cleared.
  - All outputs 0: CMD_FULL, CMD_OVF, SEND_BYTE, BYTE_TO_SEND=8'h00, READ_ENABLE, BUSY, DONE, ERROR, ERR_CODE=2'b00.
  - Reset mid-operation abandons the byte in flight with no DONE/ERROR pulse.
- Queue:
  - Write accepted when CMD_WR && !CMD_FULL.
  - Write while full is dropped and CMD_OVF pulses, even if a pop occurs in the same cycle.
  - Simultaneous accepted write and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, SEND, WAIT_SENT, WAIT_ACK.
  - IDLE: if queue not empty, latch head into BYTE_TO_SEND, clear retry count, go to SEND.
  - Latency: CMD_WR sampled at edge E0 into an empty idle queue means SEND is entered at E2.
  - SEND: SEND_BYTE=1 for exactly this one cycle, clear timer, then go to WAIT_SENT.
  - WAIT_SENT:
    - BYTE_SENT: go to WAIT_ACK and clear timer.
    - Timer reaches ACK_TIMEOUT-1: error 01.
  - WAIT_ACK, on BYTE_READY (other bytes are ignored):
    - BYTE_ERROR_CODE==0 and BYTE_READ==FA: pop head, DONE pulse, go to IDLE.
    - BYTE_READ==FC with error code 0: error 10.
    - BYTE_READ==FE, or BYTE_ERROR_CODE!=0:
      - If retry < MAX_RETRY: retry++, go to SEND, resending the same byte.
      - Else: error 11.
  - WAIT_ACK timeout: timer reaches ACK_TIMEOUT-1 gives error 01. BYTE_READY wins over timeout in the same cycle.
- Error action: pop head, ERROR pulse, ERR_CODE updated (held until the next error or reset), go to IDLE.
- BYTE_TO_SEND is held stable from SEND until returning to IDLE.
- READ_ENABLE=1 in WAIT_SENT and WAIT_ACK only.
- BUSY is combinational: (state!=IDLE) || count!=0.
- DONE and ERROR are never high in the same cycle.

Optional Feature:
MOUSE_CMD_ERR_FLUSH_EN
- Defined: on any error, the whole queue is flushed in the same cycle the ERROR pulse is issued, so parameter bytes of a failed multi-byte command are never sent. A CMD_WR in that cycle is also discarded.
- Undefined: only the failed head byte is popped and sequencing continues with the next queued byte.

Test Plan:
- Write F4; mouse returns FA 10 cycles after BYTE_SENT -> SEND_BYTE pulse at E2 with BYTE_TO_SEND=F4; DONE one cycle; BUSY falls; ERR_CODE=00.
- Write F3,64 back-to-back; both ACKed with FA -> two SEND_BYTE pulses carrying F3 then 64; two DONE pulses; no ERROR.
- Write E8; mouse replies FE, FE, FA -> three SEND_BYTE pulses, all with E8; one DONE.
- Write E8 with MAX_RETRY=2; mouse replies FE three times -> three sends; ERROR pulse; ERR_CODE=11.
- ACK_TIMEOUT=20; write FF; BYTE_SENT given, no reply -> ERROR exactly 20 cycles after entering WAIT_ACK; ERR_CODE=01.
- Write F3,C8, then FC reply to F3 -> ERR_CODE=10. With MOUSE_CMD_ERR_FLUSH_EN, C8 is never sent and BUSY falls. Without it, C8 is sent next. Separately: five writes into a depth-4 queue while stalled -> CMD_FULL=1, CMD_OVF pulse on the fifth write.

Source files
------------

// File: rtl/mouse_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// mouse_cmd_sequencer
//
// Host-side command sequencer for the PS/2 mouse link. Command bytes written by
// the processor bus are queued. For each byte the sequencer drives the PS/2
// transmitter handshake, waits for the mouse ACK (FA), resends on FE or on a
// receiver error, and reports DONE or ERROR per byte.
//
// Handshake semantics: SEND_BYTE is a one-cycle request carrying BYTE_TO_SEND.
// BYTE_SENT and BYTE_READY are one-cycle strobes from the transmitter and the
// receiver. A strobe is only acted on in the state that waits for it. CMD_WR is
// accepted on any cycle where the queue is not full. There is no backpressure
// other than CMD_FULL, and CMD_OVF flags a dropped write.
//
// Parameters:
//   FIFO_DEPTH  : command queue depth (power of 2, >= 2)
//   ACK_TIMEOUT : cycles allowed in each wait state (>= 2)
//   MAX_RETRY   : resend attempts per byte after the first send
//
// Ports:
//   CLK, RESET (synchronous, active low)
//   CMD_WR / CMD_DATA / CMD_FULL / CMD_OVF    : bus-side command queue
//   SEND_BYTE / BYTE_TO_SEND / BYTE_SENT      : PS/2 transmitter handshake
//   READ_ENABLE / BYTE_READ / BYTE_ERROR_CODE / BYTE_READY : PS/2 receiver
//   BUSY / DONE / ERROR / ERR_CODE            : status to the bus
//   DBG_STATE                                 : current FSM state (debug)
//
// Optional build macro: MOUSE_CMD_ERR_FLUSH_EN
//   When defined, an error flushes the whole queue in the cycle the error is
//   decided. A write arriving in that cycle is discarded. This prevents the
//   parameter bytes of a failed multi-byte command from being sent.
// -----------------------------------------------------------------------------
module mouse_cmd_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 50000,
  parameter int MAX_RETRY   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_WR,
  input  logic [7:0] CMD_DATA,
  output logic       CMD_FULL,
  output logic       CMD_OVF,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic [1:0] ERR_CODE,
  output logic [1:0] DBG_STATE
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [7:0] ACK_BYTE    = 8'hFA;
  localparam logic [7:0] NACK_BYTE   = 8'hFC;
  localparam logic [7:0] RESEND_BYTE = 8'hFE;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_SENT = 2'd2,
    S_WAIT_ACK  = 2'd3
  } state_t;

  // ---------------- registers ----------------
  state_t          state, state_d;
  logic [TW-1:0]   timer, timer_d;
  logic [RW-1:0]   retry, retry_d;
  logic [7:0]      byte_q, byte_d;
  logic            head_loaded, head_loaded_d;
  logic            done_q, error_q;
  logic [1:0]      err_code_q;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  // ---------------- combinational controls ----------------
  logic            full;
  logic            push;
  logic            pop;
  logic            done_ev;
  logic            err_ev;
  logic [1:0]      err_val;
  logic            send_req;
  logic            read_en;
  logic            timed_out;

  assign full = (count == CW'(FIFO_DEPTH));

`ifdef MOUSE_CMD_ERR_FLUSH_EN
  assign push = CMD_WR && !full && !err_ev;
`else
  assign push = CMD_WR && !full;
`endif
  assign pop  = done_ev || err_ev;

  assign timed_out = (timer == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d       = state;
    timer_d       = timer;
    retry_d       = retry;
    byte_d        = byte_q;
    head_loaded_d = head_loaded;
    done_ev       = 1'b0;
    err_ev        = 1'b0;
    err_val       = err_code_q;
    send_req      = 1'b0;
    read_en       = 1'b0;

    case (state)
      S_IDLE: begin
        // The head byte is fetched through a registered read. IDLE spends one
        // cycle loading BYTE_TO_SEND before it issues the request.
        if (count != '0) begin
          if (!head_loaded) begin
            byte_d        = mem[rd_ptr];
            head_loaded_d = 1'b1;
          end else begin
            head_loaded_d = 1'b0;
            retry_d       = '0;
            state_d       = S_SEND;
          end
        end
      end

      S_SEND: begin
        send_req = 1'b1;
        timer_d  = '0;
        state_d  = S_WAIT_SENT;
      end

      S_WAIT_SENT: begin
        read_en = 1'b1;
        if (BYTE_SENT) begin
          timer_d = '0;
          state_d = S_WAIT_ACK;
        end else if (timed_out) begin
          err_ev  = 1'b1;
          err_val = 2'b01;
        end else begin
          timer_d = timer + TW'(1);
        end
      end

      S_WAIT_ACK: begin
        read_en = 1'b1;
        // A receiver strobe takes priority over a timeout in the same cycle.
        // Bytes that are neither ACK, NACK nor resend are ignored, and the
        // timer keeps running.
        if (BYTE_READY && BYTE_ERROR_CODE == 2'b00 && BYTE_READ == ACK_BYTE) begin
          done_ev = 1'b1;
        end else if (BYTE_READY && BYTE_ERROR_CODE == 2'b00 && BYTE_READ == NACK_BYTE) begin
          err_ev  = 1'b1;
          err_val = 2'b10;
        end else if (BYTE_READY && (BYTE_ERROR_CODE != 2'b00 || BYTE_READ == RESEND_BYTE)) begin
          if (retry < RW'(MAX_RETRY)) begin
            retry_d = retry + RW'(1);
            state_d = S_SEND;
          end else begin
            err_ev  = 1'b1;
            err_val = 2'b11;
          end
        end else if (timed_out) begin
          err_ev  = 1'b1;
          err_val = 2'b01;
        end else begin
          timer_d = timer + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (done_ev || err_ev) begin
      state_d       = S_IDLE;
      head_loaded_d = 1'b0;
    end
  end

  // ---------------- state and queue registers ----------------
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= S_IDLE;
      timer       <= '0;
      retry       <= '0;
      byte_q      <= 8'h00;
      head_loaded <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'b00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      retry       <= retry_d;
      byte_q      <= byte_d;
      head_loaded <= head_loaded_d;
      done_q      <= done_ev;
      error_q     <= err_ev;
      if (err_ev) err_code_q <= err_val;

`ifdef MOUSE_CMD_ERR_FLUSH_EN
      if (err_ev) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else
`endif
      begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= CMD_DATA;
  end

  // ---------------- outputs ----------------
  assign CMD_FULL     = full;
  assign CMD_OVF      = CMD_WR && full;
  assign SEND_BYTE    = send_req;
  assign BYTE_TO_SEND = byte_q;
  assign READ_ENABLE  = read_en;
  assign BUSY         = (state != S_IDLE) || (count != '0);
  assign DONE         = done_q;
  assign ERROR        = error_q;
  assign ERR_CODE     = err_code_q;
  assign DBG_STATE    = state;

endmodule

// File: tb/tb_mouse_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mouse_cmd_sequencer
//
// Bench for mouse_cmd_sequencer (FIFO_DEPTH=4, ACK_TIMEOUT=20, MAX_RETRY=2).
// A cycle table covers the single-byte F4 transaction cycle by cycle.
// Hand-written sequences cover multi-byte commands, resends, the resend limit,
// both timeouts, NACK (with or without MOUSE_CMD_ERR_FLUSH_EN), queue overflow
// and reset mid-operation. A monitor compares every SEND_BYTE against an
// expected-byte queue and counts DONE/ERROR pulses.
// -----------------------------------------------------------------------------
module tb_mouse_cmd_sequencer;

  // ---------------- clock / reset / DUT ----------------
  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       CMD_WR = 1'b0;
  logic [7:0] CMD_DATA = 8'h00;
  logic       BYTE_SENT = 1'b0;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       BYTE_READY = 1'b0;
  logic       CMD_FULL, CMD_OVF, SEND_BYTE, READ_ENABLE, BUSY, DONE, ERROR;
  logic [7:0] BYTE_TO_SEND;
  logic [1:0] ERR_CODE, DBG_STATE;

  always #5 CLK = ~CLK;

  mouse_cmd_sequencer #(.FIFO_DEPTH(4), .ACK_TIMEOUT(20), .MAX_RETRY(2)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_WR(CMD_WR), .CMD_DATA(CMD_DATA),
    .CMD_FULL(CMD_FULL), .CMD_OVF(CMD_OVF), .SEND_BYTE(SEND_BYTE),
    .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_CODE(ERR_CODE),
    .DBG_STATE(DBG_STATE)
  );

  // {send, byte_to_send, read_en, busy, done, error, err_code, full, ovf}
  logic [16:0] obs;
  assign obs = {SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, BUSY, DONE, ERROR,
                ERR_CODE, CMD_FULL, CMD_OVF};

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET) begin
      if (SEND_BYTE) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL send_unexpected act=%h exp=none", BYTE_TO_SEND);
        end else begin
          check("send_byte", {24'h0, BYTE_TO_SEND}, {24'h0, exp_q.pop_front()});
        end
      end
      if (DONE) done_cnt++;
      if (ERROR) err_cnt++;
      if (DONE || ERROR) check("done_error_excl", {31'h0, DONE & ERROR}, 32'h0);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [7:0]  data;
    logic        sent;
    logic        ready;
    logic [7:0]  rbyte;
    logic [16:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic sent,
                              input logic ready, input logic [7:0] rb,
                              input logic snd, input logic [7:0] bts, input logic ren,
                              input logic busy, input logic done);
    vec_t v;
    v.wr = wr; v.data = d; v.sent = sent; v.ready = ready; v.rbyte = rb;
    v.exp = {snd, bts, ren, busy, done, 1'b0, 2'b00, 1'b0, 1'b0};
    return v;
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic write_byte(input logic [7:0] d);
    CMD_WR = 1'b1; CMD_DATA = d;
    @(posedge CLK); #1;
    CMD_WR = 1'b0;
  endtask

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (SEND_BYTE) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_send act=timeout exp=SEND_BYTE");
    end
  endtask

  // Transmitter done, then the mouse reply three cycles later.
  task automatic ack_tail(input logic [7:0] reply, input logic [1:0] rerr);
    BYTE_SENT = 1'b1;
    @(posedge CLK); #1;
    BYTE_SENT = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    BYTE_READ = reply; BYTE_ERROR_CODE = rerr; BYTE_READY = 1'b1;
    @(posedge CLK); #1;
    BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic respond(input logic [7:0] reply, input logic [1:0] rerr);
    bit ok;
    wait_send(ok);
    @(posedge CLK); #1;
    if (ok) ack_tail(reply, rerr);
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge CLK);
      if (!BUSY) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      total++; bad++;
      $display("FAIL %s act=busy exp=idle", name);
    end
    @(posedge CLK); #1;
  endtask

  // ---------------- test ----------------
  initial begin
    int  d0, e0, n;
    bit  ok;

    // F4 transaction, one row per cycle; FA arrives 10 cycles after BYTE_SENT.
    tbl[0]  = mk(1, 8'hF4, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(0, 8'h00, 0, 0, 8'h00,  0, 8'h00, 0, 1, 0);
    tbl[2]  = mk(0, 8'h00, 0, 0, 8'h00,  0, 8'hF4, 0, 1, 0);
    tbl[3]  = mk(0, 8'h00, 0, 0, 8'h00,  1, 8'hF4, 0, 1, 0);
    tbl[4]  = mk(0, 8'h00, 1, 0, 8'h00,  0, 8'hF4, 1, 1, 0);
    for (int i = 5; i < 14; i++)
      tbl[i] = mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hF4, 1, 1, 0);
    tbl[14] = mk(0, 8'h00, 0, 1, 8'hFA,  0, 8'hF4, 1, 1, 0);
    tbl[15] = mk(0, 8'h00, 0, 0, 8'h00,  0, 8'hF4, 0, 0, 1);
    tbl[16] = mk(0, 8'h00, 0, 0, 8'h00,  0, 8'hF4, 0, 0, 0);

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", {15'h0, obs}, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b1;

    // Table: single F4 command
    exp_q.push_back(8'hF4);
    for (int i = 0; i < NV; i++) begin
      CMD_WR = tbl[i].wr; CMD_DATA = tbl[i].data; BYTE_SENT = tbl[i].sent;
      BYTE_READY = tbl[i].ready; BYTE_READ = tbl[i].rbyte;
      @(negedge CLK);
      check($sformatf("vec%0d", i), {15'h0, obs}, {15'h0, tbl[i].exp});
      @(posedge CLK); #1;
    end

    // F3, 64 back-to-back, both ACKed
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(8'hF3); exp_q.push_back(8'h64);
    write_byte(8'hF3); write_byte(8'h64);
    respond(8'hFA, 2'b00); respond(8'hFA, 2'b00);
    wait_idle("f3_64_idle");
    check("f3_64_done", d0 + 2, done_cnt);
    check("f3_64_err", e0, err_cnt);

    // E8 with FE, FE, FA
    d0 = done_cnt; e0 = err_cnt;
    repeat (3) exp_q.push_back(8'hE8);
    write_byte(8'hE8);
    respond(8'hFE, 2'b00); respond(8'hFE, 2'b00); respond(8'hFA, 2'b00);
    wait_idle("resend_ok_idle");
    check("resend_ok_done", d0 + 1, done_cnt);
    check("resend_ok_err", e0, err_cnt);

    // E8 resend limit: FE, receiver error, FE -> error 11
    d0 = done_cnt; e0 = err_cnt;
    repeat (3) exp_q.push_back(8'hE8);
    write_byte(8'hE8);
    respond(8'hFE, 2'b00); respond(8'h00, 2'b01); respond(8'hFE, 2'b00);
    wait_idle("retry_limit_idle");
    check("retry_limit_err", e0 + 1, err_cnt);
    check("retry_limit_done", d0, done_cnt);
    check("retry_limit_code", {30'h0, ERR_CODE}, 32'h3);

    // WAIT_ACK timeout: ERROR appears 20 cycles after entering WAIT_ACK
    exp_q.push_back(8'hFF);
    write_byte(8'hFF);
    wait_send(ok);
    @(posedge CLK); #1;
    BYTE_SENT = 1'b1;
    @(posedge CLK); #1;
    BYTE_SENT = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge CLK);
      if (ERROR) break;
      n++;
    end
    check("ack_timeout_cycles", n, 20);
    check("ack_timeout_code", {30'h0, ERR_CODE}, 32'h1);
    wait_idle("ack_timeout_idle");

    // WAIT_SENT timeout: no BYTE_SENT at all
    exp_q.push_back(8'h55);
    write_byte(8'h55);
    wait_send(ok);
    n = 0;
    while (n < 100) begin
      @(negedge CLK);
      n++;
      if (ERROR) break;
    end
    check("sent_timeout_cycles", n, 21);
    wait_idle("sent_timeout_idle");

    // F3, C8 with NACK on F3. The flush build never sends C8.
    exp_q.push_back(8'hF3);
`ifndef MOUSE_CMD_ERR_FLUSH_EN
    exp_q.push_back(8'hC8);
`endif
    write_byte(8'hF3); write_byte(8'hC8);
    respond(8'hFC, 2'b00);
    @(negedge CLK);
    check("nack_error", {31'h0, ERROR}, 32'h1);
    check("nack_code", {30'h0, ERR_CODE}, 32'h2);
`ifdef MOUSE_CMD_ERR_FLUSH_EN
    check("nack_busy_flush", {31'h0, BUSY}, 32'h0);
    @(posedge CLK); #1;
    repeat (30) @(posedge CLK);
    #1;
`else
    check("nack_busy_keep", {31'h0, BUSY}, 32'h1);
    @(posedge CLK); #1;
    d0 = done_cnt;
    respond(8'hFA, 2'b00);
    wait_idle("nack_next_idle");
    check("nack_next_done", d0 + 1, done_cnt);
`endif

    // Overflow: five writes into the depth-4 queue while the head is stalled
    wait_idle("ovf_pre_idle");
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      CMD_WR = 1'b1; CMD_DATA = 8'hA0 + 8'(i);
      @(negedge CLK);
      if (i == 3) check("ovf_not_yet", {30'h0, CMD_FULL, CMD_OVF}, 32'h0);
      if (i == 4) check("ovf_pulse", {30'h0, CMD_FULL, CMD_OVF}, 32'h3);
      @(posedge CLK); #1;
    end
    CMD_WR = 1'b0;
    @(negedge CLK);
    check("ovf_cleared", {30'h0, CMD_FULL, CMD_OVF}, 32'h2);
    @(posedge CLK); #1;
    d0 = done_cnt;
    ack_tail(8'hFA, 2'b00);
    repeat (3) respond(8'hFA, 2'b00);
    wait_idle("ovf_drain_idle");
    check("ovf_drain_done", d0 + 4, done_cnt);

    // Reset mid-operation: byte abandoned, outputs and ERR_CODE cleared
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(8'h77);
    write_byte(8'h77);
    wait_send(ok);
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("midop_reset_outputs", {15'h0, obs}, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("after_reset_idle", {15'h0, obs}, 32'h0);
    check("midop_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
